// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph table, decoder and sizing helper.
// Glyphs are active-low, bit 6 = segment a ... bit 0 = segment g.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_4     = 7'b1001100;
    localparam logic [6:0] GLYPH_5     = 7'b0100100;
    localparam logic [6:0] GLYPH_6     = 7'b0100000;
    localparam logic [6:0] GLYPH_7     = 7'b0001111;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0000100;
    localparam logic [6:0] GLYPH_E     = 7'b0110000;
    localparam logic [6:0] GLYPH_MINUS = 7'b1111110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam int MAX_DIGITS = 8;

    function automatic logic [6:0] seg7_decode(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            4'd12:   g = GLYPH_E;
            4'd15:   g = GLYPH_MINUS;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Digit-index width; a single-digit bank still gets a 1-bit index.
    function automatic int seg7_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational code-to-glyph decoder used on the currently scanned digit.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [1:7] seg
);

    assign seg = seg7_decode(code);

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with leading-zero
// blanking, per-digit enables and tear-free loading at frame boundaries.
module seven_segment_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [1:7]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    applied
);

    localparam int IDX_W = seg7_idx_w(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]             cnt;
    logic [IDX_W-1:0]             idx;
    logic [NUM_DIGITS-1:0][3:0]   pend_d, act_d;
    logic [NUM_DIGITS-1:0]        pend_en, act_en;
    logic                         pend_valid;
    logic                         bnd_q, apl_q;
    logic [NUM_DIGITS-1:0]        lz;
    logic                         cnt_wrap, idx_wrap, bnd, visible;
    logic [1:7]                   glyph;

    assign cnt_wrap = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_wrap = (idx == IDX_W'(NUM_DIGITS - 1));
    assign bnd      = cnt_wrap && idx_wrap;

    // A digit is a leading zero when it and every more-significant code are 0.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        if (gi == 0) begin : g_lsd
            assign lz[gi] = 1'b0;
        end else begin : g_msd
            assign lz[gi] = (LZ_BLANK != 0) && (act_d[NUM_DIGITS-1:gi] == '0);
        end
    end

    assign visible = act_en[idx] && !lz[idx];

    seg7_glyph_decode u_dec (
        .code (act_d[idx]),
        .seg  (glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            pend_d     <= '0;
            pend_en    <= '0;
            pend_valid <= 1'b0;
            act_d      <= '0;
            act_en     <= '0;
            bnd_q      <= 1'b0;
            apl_q      <= 1'b0;
            seg        <= '1;
            an         <= '1;
            frame_tick <= 1'b0;
            applied    <= 1'b0;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap)
                idx <= idx_wrap ? '0 : idx + 1'b1;

            if (bnd && pend_valid) begin
                act_d      <= pend_d;
                act_en     <= pend_en;
                pend_valid <= 1'b0;
            end
            // A load on the boundary cycle stays pending for the next frame.
            if (load) begin
                pend_d     <= digits;
                pend_en    <= digit_en;
                pend_valid <= 1'b1;
            end

            // Extra stage keeps the pulses aligned with the first digit-0 output.
            bnd_q      <= bnd;
            apl_q      <= bnd && pend_valid;
            frame_tick <= bnd_q;
            applied    <= apl_q;

            an  <= visible ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg <= visible ? glyph : '1;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench: stimulus queues one expected frame per frame_tick,
// the monitor pops on each tick and checks the four scan slots.
module tb_seven_segment_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic        load;
    logic [1:7]  seg;
    logic [3:0]  an;
    logic        frame_tick;
    logic        applied;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit                   ap;
        logic [3:0][3:0]      an;
        logic [3:0][6:0]      seg;
    } rec_t;

    typedef struct {
        logic [15:0]          digits;
        logic [3:0]           en;
        logic [3:0][3:0]      an;
        logic [3:0][6:0]      seg;
    } vec_t;

    rec_t            exp_q[$];
    vec_t            vt[9];
    logic [3:0][3:0] cur_an;
    logic [3:0][6:0] cur_seg;
    bit              ap_nxt;

    seven_segment_scan_driver #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .LZ_BLANK   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digits    (digits),
        .digit_en  (digit_en),
        .load      (load),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick),
        .applied   (applied)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_tick && n < 40);
        checks++;
        if (!frame_tick) begin
            errors++;
            $display("FAIL tick_timeout waited=%0d cycles expected<=17", n);
        end
    endtask

    task automatic frames(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r.ap  = ap_nxt;
            r.an  = cur_an;
            r.seg = cur_seg;
            exp_q.push_back(r);
            ap_nxt = 1'b0;
            wait_tick();
        end
    endtask

    task automatic load_v(input logic [15:0] d, input logic [3:0] e);
        digits   = d;
        digit_en = e;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load     = 1'b0;
        digits   = 16'hFFFF;
        digit_en = 4'h0;
    endtask

    task automatic use_vec(input int k);
        load_v(vt[k].digits, vt[k].en);
        cur_an  = vt[k].an;
        cur_seg = vt[k].seg;
        ap_nxt  = 1'b1;
    endtask

    task automatic set_dark();
        cur_an  = {4{4'b1111}};
        cur_seg = {4{7'b1111111}};
    endtask

    // Monitor: every tick pops one frame, then samples the first cycle of each slot.
    initial begin
        rec_t e;
        int   ph, last, cyc, d;
        bit   act, have_last;
        act = 0; have_last = 0; cyc = 0; ph = 0; last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            chk("applied_without_tick", {31'd0, applied && !frame_tick}, 32'd0);
            if (reset) begin
                act       = 0;
                have_last = 0;
            end else if (frame_tick) begin
                if (have_last) chk("tick_period", cyc - last, 32'd16);
                last      = cyc;
                have_last = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    act = 0;
                    $display("FAIL unexpected_tick at cycle %0d with empty queue", cyc);
                end else begin
                    e   = exp_q.pop_front();
                    act = 1;
                    ph  = 0;
                    chk("applied_at_tick", {31'd0, applied}, {31'd0, e.ap});
                end
            end else if (act) begin
                ph++;
            end
            if (act && !reset && (ph % 4) == 0) begin
                d = ph / 4;
                chk($sformatf("an_slot%0d", d), {28'd0, an}, {28'd0, e.an[d]});
                chk($sformatf("seg_slot%0d", d), {25'd0, seg}, {25'd0, e.seg[d]});
                if (ph == 12) act = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout queue=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        // Hand-computed slot tables, listed digit 3 first.
        vt[0] = '{16'h1234, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
        vt[1] = '{16'h0050, 4'hF, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                  {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}};
        vt[2] = '{16'h0000, 4'hF, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                  {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
        vt[3] = '{16'hFCAB, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b1111110, 7'b0110000, 7'b1111111, 7'b1111111}};
        vt[4] = '{16'h00A0, 4'hF, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                  {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
        vt[5] = '{16'h1234, 4'b0101, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                  {7'b1111111, 7'b0010010, 7'b1111111, 7'b1001100}};
        vt[6] = '{16'h2222, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}};
        vt[7] = '{16'h8967, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b0000000, 7'b0000100, 7'b0100000, 7'b0001111}};
        vt[8] = '{16'h1111, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111}};

        reset = 1'b1; digits = '0; digit_en = '0; load = 1'b0; ap_nxt = 1'b0;
        set_dark();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        chk("rst_applied", {31'd0, applied}, 32'd0);
        reset = 1'b0;

        // No load yet: dark frames, ticks keep coming.
        frames(2);

        use_vec(0); frames(2);
        use_vec(1); frames(1);
        use_vec(2); frames(1);
        use_vec(3); frames(1);
        use_vec(4); frames(1);
        use_vec(5); frames(1);

        // Two loads inside one frame: only the last shows, one applied pulse.
        repeat (4) @(posedge clk);
        #1;
        load_v(16'h1111, 4'hF);
        @(posedge clk);
        #1;
        use_vec(6);
        frames(2);

        // Load captured on the boundary edge itself shows one frame later.
        repeat (14) @(posedge clk);
        #1;
        load_v(vt[7].digits, vt[7].en);
        frames(1);
        cur_an  = vt[7].an;
        cur_seg = vt[7].seg;
        ap_nxt  = 1'b1;
        frames(2);

        // Reset while digit 2 is lit and a load is pending.
        load_v(vt[8].digits, vt[8].en);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_seg", {25'd0, seg}, 32'h7F);
        chk("midrst_an", {28'd0, an}, 32'hF);
        chk("midrst_frame_tick", {31'd0, frame_tick}, 32'd0);
        chk("midrst_applied", {31'd0, applied}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        set_dark();
        ap_nxt = 1'b0;
        frames(3);

        repeat (16) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_driver.md
Name: seven_segment_scan_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment bank. It decodes one 4-bit code per digit into active-low segments and scans the digit anodes at a programmable refresh rate. Optional leading-zero blanking and per-digit enables are supported. New values are loaded tear-free at frame boundaries. It sits between the calculator datapath/memory and the board display pins.

Parameters:
NUM_DIGITS, 4, digits in the bank; legal range 1..8.
REFRESH_DIV, 100000, clk cycles each digit is lit; must be >= 2.
LZ_BLANK, 1, 1 = blank leading zeros (digit 0 is never blanked); 0 = disabled.

Ports:
clk  input  1  system clock; the block uses this single clock only.
reset  input  1  synchronous, active-high reset.
digits  input  4*NUM_DIGITS  code per digit; digit i = digits[4i+3:4i]; digit 0 is least significant.
digit_en  input  NUM_DIGITS  per-digit enable; 0 = digit dark.
load  input  1  1-cycle strobe; captures digits/digit_en into the pending register.
seg  output  7  [1:7] = segments a..g, active low.
an  output  NUM_DIGITS  anode select, active low, one-hot-low while lit.
frame_tick  output  1  1-cycle pulse at the start of each frame (digit 0 lit).
applied  output  1  1-cycle pulse when pending data became active.

Behaviour:
- Glyphs, active-low, a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - 12 ('E') = 0110000; 15 (minus) = 1111110.
  - 10, 11, 13, 14 = blank (1111111).
- Reset (synchronous):
  - cnt=0, idx=0, pend_valid=0.
  - Pending and active data = 0; active digit_en = all 0.
  - seg=1111111, an=all 1s, frame_tick=0, applied=0.
- Refresh counter:
  - cnt increments every cycle.
  - At cnt==REFRESH_DIV-1: cnt<=0 and idx<=idx+1. At idx==NUM_DIGITS-1, idx wraps to 0.
- Outputs are registered and lag idx and active data by 1 cycle.
  - an = ~(1<<idx) when the digit is visible, else all 1s.
  - seg = glyph of the active code, or 1111111 when the digit is not visible.
- Visible = active_en[idx] AND NOT lz_blank[idx].
- Leading-zero blanking (LZ_BLANK=1):
  - lz_blank[i]=1 iff i>0 and every active code at index >= i equals 0.
  - Any non-zero code (including 15 and the blank codes) stops suppression.
- Load/apply:
  - load=1 copies digits/digit_en into pending and sets pend_valid. A later load before apply overwrites (last wins).
  - Frame boundary = the edge where cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1. At that edge, if pend_valid, active<=pending and pend_valid<=0.
  - applied is high the following cycle, aligned with frame_tick.
  - load on the boundary cycle itself is captured into pending but applied only at the next boundary.
- frame_tick: high the cycle after every frame boundary, in the same cycle an[0] is first driven for the new frame.
- NUM_DIGITS=1: idx stays 0; a boundary occurs every REFRESH_DIV cycles.
- Reset asserted mid-frame aborts the scan and discards any pending load; reset values apply on the next edge.
- digits/digit_en are ignored when load=0; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package seg7_pkg holds:
  - the GLYPH_* constants (0-9, E, MINUS, BLANK);
  - the function seg7_decode(code[3:0]) -> [1:7];
  - the localparam idx width $clog2(NUM_DIGITS) (minimum 1).
- One sub-module, seg7_glyph_decode: a purely combinational wrapper around seg7_decode, instantiated once on the muxed active code.
- Counter, scan, blanking and load logic stay in the top module.

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=4.
- Reset → seg=1111111, an=1111, frame_tick=0. After release with no load: an stays 1111 (enables 0) while frame_tick pulses every 16 cycles.
- load digits=0x1234, en=1111 → from the next frame, each digit lit for 4 cycles. Sequence an=1110/seg=1001100, 1101/0000110, 1011/0010010, 0111/1001111. applied and frame_tick coincide.
- LZ_BLANK=1, load 0x0050, en=1111 → digits 3 and 2 dark (an high); digit 1 seg=0100100; digit 0 seg=0000001 (not blanked). Load 0x0000 → only digit 0 shows 0000001.
- Codes 0xFCAB loaded → digit 3 seg=1111110, digit 2 seg=0110000, digits 1 and 0 seg=1111111. Blank codes 10/11 still stop leading-zero suppression.
- Load 0x1111 at mid-frame, then 0x2222 two cycles later → only 0x2222 appears at the next boundary, with one applied pulse. Load exactly on a boundary cycle → value appears one frame later.
- Assert reset during digit 2 of a frame with a load pending → next cycle all outputs at reset values. After release, the pending value never appears.
